cache_port_arbiter: RTL and testbench
=====================================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 8: data bus width in bits per port.
REQ-002 Parameter ADDRESSWIDTH, default 32: address width in bits per port.
REQ-003 Parameter OPWIDTH, default 4: operation code width in bits.
REQ-004 Parameter NUM_PORTS, default 4: master port count, legal range 1..16.
REQ-005 Parameter TIMEOUT, default 255: maximum slave wait cycles; 0 disables the timeout.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clock  input  1  rising-edge clock for all state.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 m_request  input  NUM_PORTS  per-port 4-phase request.
REQ-010 m_operation  input  NUM_PORTS*OPWIDTH  per-port operation, port i at slice i.
REQ-011 m_addr  input  NUM_PORTS*ADDRESSWIDTH  per-port address.
REQ-012 m_wdata  input  NUM_PORTS*DATAWIDTH  per-port write data.
REQ-013 m_valid  output  NUM_PORTS  per-port 4-phase acknowledge.
REQ-014 m_evict  output  NUM_PORTS  per-port eviction flag, meaningful while m_valid[i]=1.
REQ-015 m_rdata  output  DATAWIDTH  read data, shared by all ports, meaningful while m_valid[i]=1.
REQ-016 s_request, s_operation, s_addr, s_wdata  output  1/OPWIDTH/ADDRESSWIDTH/DATAWIDTH  request to the cache.
REQ-017 s_valid, s_evict  input  1/1  cache acknowledge and eviction flag.
REQ-018 s_rdata  input  DATAWIDTH  cache read data.
REQ-019 grant_id  output  $clog2(NUM_PORTS), minimum 1 bit  port currently owning the cache.
REQ-020 timeout  output  1  sticky slave-timeout flag.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_DROP and RELEASE.
REQ-022 In IDLE with any m_request bit high, the arbiter SHALL select the first requesting port at or after rr_ptr, wrapping modulo NUM_PORTS, latch that port's operation, address and wdata into s_* and grant_id, and enter ISSUE on the next cycle.
REQ-023 s_request SHALL be 1 exactly in ISSUE and WAIT_DROP, and s_* fields SHALL hold stable over that interval.
REQ-024 In ISSUE, when s_valid=1 the arbiter SHALL capture s_rdata and s_evict, assert m_valid[grant_id] and m_evict[grant_id] on the next cycle, and enter WAIT_DROP.
REQ-025 In WAIT_DROP, when m_request[grant_id]=0 the arbiter SHALL clear m_valid, m_evict and s_request on the next cycle and enter RELEASE.
REQ-026 In RELEASE, when s_valid=0 the arbiter SHALL enter IDLE and set rr_ptr to (grant_id+1) mod NUM_PORTS.
REQ-027 Best-case latency SHALL be 1 cycle from m_request rise to s_request rise, and 1 cycle from s_valid rise to m_valid rise.
REQ-028 m_valid SHALL be one-hot or zero at all times, and a non-granted port's m_valid SHALL be 0.
REQ-029 Requests arriving outside IDLE SHALL be held pending and considered at the next IDLE, and none SHALL be dropped.
REQ-030 A request raised and dropped entirely outside IDLE SHALL be ignored.
REQ-031 A granted master dropping m_request before m_valid is a protocol error: the transaction SHALL complete unchanged, with WAIT_DROP exiting on its first cycle.
REQ-032 In IDLE, s_valid=1 SHALL be ignored.
REQ-033 In ISSUE a wait counter SHALL increment each cycle, saturating.
REQ-034 When TIMEOUT>0 and the wait counter reaches TIMEOUT, timeout SHALL become 1 and stay 1 until reset; the FSM SHALL keep waiting.
REQ-035 With NUM_PORTS=1, grant_id SHALL be constant 0 and rr_ptr SHALL never change.

Reset
REQ-036 Reset SHALL force state=IDLE, rr_ptr=0, grant_id=0, the wait counter to 0 and timeout=0.
REQ-037 Reset SHALL drive m_valid, m_evict, m_rdata, s_request, s_operation, s_addr and s_wdata to all zeros.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction, and the output values SHALL hold from the cycle after reset is sampled.

Verification
REQ-039 Single port: port 2 sends addr 0x1000, op 1; cache s_valid after 3 cycles with rdata 0xA5 -> s_request at cycle 1, m_valid[2] one cycle after s_valid, m_rdata=0xA5, full 4-phase completes.
REQ-040 All 4 ports request together from reset -> grants occur in order 0,1,2,3, each transaction completing before the next s_request rise.
REQ-041 Port 3 completes, then ports 0 and 3 request together -> port 0 is granted because rr_ptr=0 after wrap.
REQ-042 Cache returns s_evict=1 with s_valid for port 1 -> m_evict[1]=1 concurrent with m_valid[1], and all other m_evict bits stay 0.
REQ-043 TIMEOUT=8 and the cache is silent for 20 cycles -> timeout=1 after 8 ISSUE cycles; a late s_valid still completes the transaction normally.
REQ-044 Reset pulsed while in WAIT_DROP -> next cycle all outputs are zero and state is IDLE; a fresh request is served starting from port 0.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter granting one of NUM_PORTS 4-phase masters access to a single cache port.
// A grant is held through the full request/acknowledge/drop/release handshake on both sides.
module cache_port_arbiter #(
   parameter int DATAWIDTH    = 8,
   parameter int ADDRESSWIDTH = 32,
   parameter int OPWIDTH      = 4,
   parameter int NUM_PORTS    = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_PORTS-1:0]              m_request,
   input  logic [NUM_PORTS*OPWIDTH-1:0]      m_operation,
   input  logic [NUM_PORTS*ADDRESSWIDTH-1:0] m_addr,
   input  logic [NUM_PORTS*DATAWIDTH-1:0]    m_wdata,
   output logic [NUM_PORTS-1:0]              m_valid,
   output logic [NUM_PORTS-1:0]              m_evict,
   output logic [DATAWIDTH-1:0]              m_rdata,
   output logic                              s_request,
   output logic [OPWIDTH-1:0]                s_operation,
   output logic [ADDRESSWIDTH-1:0]           s_addr,
   output logic [DATAWIDTH-1:0]              s_wdata,
   input  logic                              s_valid,
   input  logic                              s_evict,
   input  logic [DATAWIDTH-1:0]              s_rdata,
   output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
   output logic                              timeout
);

   localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PAD   = 1 << ID_W;
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DROP = 2'd2;
   localparam logic [1:0] ST_RELEASE   = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]         grant_q, grant_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    timeout_q, timeout_d;
   logic [NUM_PORTS-1:0]    m_valid_q, m_valid_d;
   logic [NUM_PORTS-1:0]    m_evict_q, m_evict_d;
   logic [DATAWIDTH-1:0]    m_rdata_q, m_rdata_d;
   logic [OPWIDTH-1:0]      s_op_q, s_op_d;
   logic [ADDRESSWIDTH-1:0] s_addr_q, s_addr_d;
   logic [DATAWIDTH-1:0]    s_wdata_q, s_wdata_d;

   // Request vector padded to a power of two so any ID_W-bit index is in range.
   logic [PAD-1:0]  req_pad;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] pick_idx;
   logic [ID_W-1:0] next_ptr;

   assign req_pad  = PAD'(m_request);
   assign next_ptr = ID_W'((int'(grant_q) + 1) % NUM_PORTS);

   // Scan downward so the closest requester at or after rr_ptr wins last.
   always_comb begin
      cand     = '0;
      pick_idx = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
         if (req_pad[cand]) pick_idx = cand;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      m_valid_d = m_valid_q;
      m_evict_d = m_evict_q;
      m_rdata_d = m_rdata_q;
      s_op_d    = s_op_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|m_request) begin
               state_d   = ST_ISSUE;
               grant_d   = pick_idx;
               cnt_d     = '0;
               s_op_d    = m_operation[int'(pick_idx)*OPWIDTH +: OPWIDTH];
               s_addr_d  = m_addr[int'(pick_idx)*ADDRESSWIDTH +: ADDRESSWIDTH];
               s_wdata_d = m_wdata[int'(pick_idx)*DATAWIDTH +: DATAWIDTH];
            end
         end
         ST_ISSUE: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // The flag only reports a stuck cache; the handshake keeps waiting.
            if (TIMEOUT > 0 && int'(cnt_q) + 1 >= TIMEOUT) timeout_d = 1'b1;
            if (s_valid) begin
               state_d   = ST_WAIT_DROP;
               m_rdata_d = s_rdata;
               m_valid_d = NUM_PORTS'(1) << grant_q;
               m_evict_d = s_evict ? (NUM_PORTS'(1) << grant_q) : '0;
            end
         end
         ST_WAIT_DROP: begin
            if (!req_pad[grant_q]) begin
               state_d   = ST_RELEASE;
               m_valid_d = '0;
               m_evict_d = '0;
            end
         end
         ST_RELEASE: begin
            if (!s_valid) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         m_valid_q <= '0;
         m_evict_q <= '0;
         m_rdata_q <= '0;
         s_op_q    <= '0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         m_valid_q <= m_valid_d;
         m_evict_q <= m_evict_d;
         m_rdata_q <= m_rdata_d;
         s_op_q    <= s_op_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
      end
   end

   assign s_request   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DROP);
   assign s_operation = s_op_q;
   assign s_addr      = s_addr_q;
   assign s_wdata     = s_wdata_q;
   assign m_valid     = m_valid_q;
   assign m_evict     = m_evict_q;
   assign m_rdata     = m_rdata_q;
   assign grant_id    = grant_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: four masters, a hand-driven cache, TIMEOUT=8.
module tb_cache_port_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int AW = 32;
   localparam int OW = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [NP-1:0]    m_request;
   logic [NP*OW-1:0] m_operation;
   logic [NP*AW-1:0] m_addr;
   logic [NP*DW-1:0] m_wdata;
   logic [NP-1:0]    m_valid;
   logic [NP-1:0]    m_evict;
   logic [DW-1:0]    m_rdata;
   logic             s_request;
   logic [OW-1:0]    s_operation;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic             s_valid;
   logic             s_evict;
   logic [DW-1:0]    s_rdata;
   logic [1:0]       grant_id;
   logic             timeout;

   int n_chk = 0;
   int n_bad = 0;

   cache_port_arbiter #(
      .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .OPWIDTH(OW), .NUM_PORTS(NP), .TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset),
      .m_request(m_request), .m_operation(m_operation), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_valid(m_valid), .m_evict(m_evict), .m_rdata(m_rdata),
      .s_request(s_request), .s_operation(s_operation), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_valid(s_valid), .s_evict(s_evict), .s_rdata(s_rdata),
      .grant_id(grant_id), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [AW-1:0] def_addr(input int p);
      return AW'(32'h2000 + p * 16);
   endfunction

   function automatic logic [OW-1:0] def_op(input int p);
      return OW'(p + 1);
   endfunction

   function automatic logic [DW-1:0] def_wd(input int p);
      return DW'(8'h30 + p);
   endfunction

   task automatic raise(input int p, input logic [AW-1:0] a, input logic [OW-1:0] op,
                        input logic [DW-1:0] wd);
      m_request[p]          = 1'b1;
      m_addr[p*AW +: AW]    = a;
      m_operation[p*OW +: OW] = op;
      m_wdata[p*DW +: DW]   = wd;
   endtask

   task automatic raise_def(input int p);
      raise(p, def_addr(p), def_op(p), def_wd(p));
   endtask

   task automatic wait_sreq();
      for (int i = 0; i < 20 && s_request !== 1'b1; i++) tick();
      chk("s_request_rise", 64'(s_request), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_evict"}, 64'(m_evict), 64'd0);
      chk({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
      chk({tag, "_s_request"}, 64'(s_request), 64'd0);
      chk({tag, "_s_operation"}, 64'(s_operation), 64'd0);
      chk({tag, "_s_addr"}, 64'(s_addr), 64'd0);
      chk({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
      chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
      chk({tag, "_timeout"}, 64'(timeout), 64'd0);
   endtask

   // Full handshake for port p, cache answering lat cycles after s_request is seen.
   task automatic serve(input int p, input logic [AW-1:0] a, input logic [OW-1:0] op,
                        input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rd,
                        input logic ev);
      wait_sreq();
      chk("grant_id", 64'(grant_id), 64'(p));
      chk("s_addr", 64'(s_addr), 64'(a));
      chk("s_operation", 64'(s_operation), 64'(op));
      chk("s_wdata", 64'(s_wdata), 64'(wd));
      repeat (lat) tick();
      chk("m_valid_early", 64'(m_valid), 64'd0);
      s_valid = 1'b1;
      s_rdata = rd;
      s_evict = ev;
      tick();
      chk("m_valid", 64'(m_valid), 64'd1 << p);
      chk("m_rdata", 64'(m_rdata), 64'(rd));
      chk("m_evict", 64'(m_evict), ev ? (64'd1 << p) : 64'd0);
      chk("s_request_hold", 64'(s_request), 64'd1);
      m_request[p] = 1'b0;
      tick();
      chk("m_valid_drop", 64'(m_valid), 64'd0);
      chk("m_evict_drop", 64'(m_evict), 64'd0);
      chk("s_request_drop", 64'(s_request), 64'd0);
      s_valid = 1'b0;
      s_evict = 1'b0;
      tick();
   endtask

   task automatic serve_def(input int p, input int lat, input logic [DW-1:0] rd, input logic ev);
      serve(p, def_addr(p), def_op(p), def_wd(p), lat, rd, ev);
   endtask

   initial begin
      reset       = 1'b1;
      m_request   = '0;
      m_operation = '0;
      m_addr      = '0;
      m_wdata     = '0;
      s_valid     = 1'b0;
      s_evict     = 1'b0;
      s_rdata     = '0;
      repeat (2) tick();
      check_all_zero("rst");
      reset = 1'b0;

      // Stray cache acknowledge while idle
      s_valid = 1'b1;
      s_rdata = 8'hFF;
      repeat (2) tick();
      chk("idle_sv_m_valid", 64'(m_valid), 64'd0);
      chk("idle_sv_s_request", 64'(s_request), 64'd0);
      chk("idle_sv_m_rdata", 64'(m_rdata), 64'd0);
      s_valid = 1'b0;
      tick();

      // Single port 2, one-cycle request latency
      raise(2, 32'h1000, 4'd1, 8'h5A);
      tick();
      chk("latency_s_request", 64'(s_request), 64'd1);
      serve(2, 32'h1000, 4'd1, 8'h5A, 2, 8'hA5, 1'b0);

      // All four from reset: grants 0,1,2,3
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int p = 0; p < NP; p++) raise_def(p);
      for (int p = 0; p < NP; p++) serve_def(p, 1 + p, 8'h40 + 8'(p), 1'b0);

      // Pointer wrapped to 0 after port 3
      raise_def(0);
      raise_def(3);
      serve_def(0, 1, 8'h77, 1'b0);
      serve_def(3, 1, 8'h88, 1'b0);

      // Eviction on port 1
      raise_def(1);
      serve_def(1, 2, 8'h99, 1'b1);

      // Silent cache: timeout after 8 ISSUE cycles, late ack still completes
      raise_def(0);
      wait_sreq();
      repeat (7) tick();
      chk("timeout_before", 64'(timeout), 64'd0);
      tick();
      chk("timeout_set", 64'(timeout), 64'd1);
      chk("timeout_still_req", 64'(s_request), 64'd1);
      serve_def(0, 11, 8'hC3, 1'b0);
      chk("timeout_sticky", 64'(timeout), 64'd1);

      // Reset in WAIT_DROP, then fresh round starts at port 0
      raise_def(2);
      wait_sreq();
      s_valid = 1'b1;
      s_rdata = 8'h3C;
      tick();
      chk("wd_m_valid", 64'(m_valid), 64'd4);
      reset     = 1'b1;
      m_request = '0;
      s_valid   = 1'b0;
      tick();
      check_all_zero("midrst");
      reset = 1'b0;
      raise_def(0);
      raise_def(2);
      serve_def(0, 1, 8'h11, 1'b0);
      serve_def(2, 1, 8'h22, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
